clkdiv_multi: RTL and testbench
===============================

Name: clkdiv_multi

Overview:
- Parametrised, multi-channel successor to the single fixed-rate clock divider.
- Runs NCH independent dividers from the 100 MHz board clock.
- Each channel's half-period is reloadable at run time through a valid/ready port, with a per-channel enable, a global phase-sync input, a square-wave output and a one-cycle tick output.
- Drives slow logic in lab designs: display scanning, debouncers, blink/step rates.

Parameters:
- NCH, 4, number of divider channels (1..16).
- DIVBITS, 26, counter and divisor width.
- CLKFREQ, 100_000_000, input clock frequency in Hz.
- DEFFREQ, 2, reset-time output frequency in Hz for every channel.
- DEFAMT, (CLKFREQ/DEFFREQ)/2, reset half-period in cycles (derived; must fit DIVBITS).
- CHW, max(1,$clog2(NCH)), channel-select width (derived).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- en  in  NCH  per-channel count enable.
- mode  in  NCH  per-channel output mode: 0 = square on sclk, 1 = tick only (sclk held 0).
- sync  in  1  restart all channels phase-aligned.
- ld_valid  in  1  divisor load request.
- ld_ready  out  1  load port can accept.
- ld_ch  in  CHW  target channel of load.
- ld_div  in  DIVBITS  new half-period in cycles.
- sclk  out  NCH  divided square-wave outputs.
- tick  out  NCH  one-cycle pulse at each terminal count.

Behaviour:
- Per channel i:
  - counter q[i] (DIVBITS).
  - terminal register t[i] = half-period − 1.
  - sclk[i] and tick[i] are registered.
- Reset (reset==0 at an edge): q=0, sclk=0, tick=0, t=DEFAMT−1, pending load cleared, ld_ready=0. ld_ready=1 from the first edge with reset==1.
- Counting (en[i]=1, no sync):
  - If q==t: q<=0; tick<=1; if mode[i]==0 then sclk<=~sclk.
  - Otherwise q<=q+1, tick<=0.
- Timing with half-period D:
  - First terminal at the D-th edge after reset release.
  - tick period is D cycles; sclk period is 2D cycles at 50% duty.
  - D=1 gives sclk = clk/2 and tick high every cycle.
- en[i]=0: q and sclk hold, tick<=0. Counting resumes from the held q.
- mode[i]==1: sclk[i]<=0 on the next edge and stays 0. tick is unaffected.
- Mode 1→0 mid-count: sclk starts at 0 and toggles at the next terminal.
- Load handshake:
  - Transfer when ld_valid && ld_ready. ld_ch and ld_div are captured into a single pending slot and ld_ready<=0.
  - ld_div==0 is clamped to 1.
  - ld_ch>=NCH: the load is accepted and discarded; ld_ready stays 1.
- Pending load application:
  - Glitch-free: t[ch] updates on the edge where channel ch reaches its terminal (q==t, with the old t). The next half-period uses the new value.
  - If the channel is disabled, apply on the next edge.
  - ld_ready<=1 on the application edge. A new load is accepted at the earliest one cycle later.
- sync==1 (all channels, priority over count, enable and mode):
  - q<=0, sclk<=0, tick<=0.
  - Any pending load is applied immediately and ld_ready<=1.
  - Counting restarts on the first edge with sync==0.
- Reset has priority over everything. Reset mid-load discards the pending load and restores DEFAMT.
- Width rule: q and t are compared at DIVBITS with no wrap beyond t. A ld_div that exceeds the range is truncated to DIVBITS by port width.

Test Plan:
- Reset with NCH=4, DEFAMT overridden to 5 for simulation, all en=1, mode=0 → every sclk toggles at edges 5, 10, 15…; tick high on exactly those cycles; ld_ready=1 one cycle after release.
- Load ch2 with ld_div=3 while q[2]=1 of t=4 → ld_ready drops; old half-period 5 completes; next half-periods are 3 cycles; ld_ready returns on the terminal edge; channels 0, 1 and 3 unchanged.
- Load ld_div=0 on ch1 → behaves as D=1: sclk[1] toggles every cycle, tick[1] constant 1.
- en[3]=0 for 7 cycles at q=2 → q[3] frozen at 2, tick[3]=0, sclk[3] held; after re-enable the terminal comes 3 cycles later.
- Channels desynchronised by enables, then sync pulsed for 1 cycle → all q=0, sclk=0; subsequent toggles coincide across channels with equal D.
- Pending load on ch0 with en[0]=0 → applied next edge. ld_ch=5 with NCH=4 → discarded, ld_ready stays 1. reset=0 mid-pending → t restored to DEFAMT−1.

Source files
------------

// File: rtl/clkdiv_multi.sv
// Multi-channel clock divider: NCH independent counters with run-time reloadable
// half-periods, per-channel enable/mode, global phase sync, square and tick outputs.
module clkdiv_multi #(
  parameter int NCH     = 4,
  parameter int DIVBITS = 26,
  parameter int CLKFREQ = 100_000_000,
  parameter int DEFFREQ = 2,
  parameter int DEFAMT  = (CLKFREQ / DEFFREQ) / 2,
  parameter int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     en,
  input  logic [NCH-1:0]     mode,
  input  logic               sync,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [CHW-1:0]     ld_ch,
  input  logic [DIVBITS-1:0] ld_div,
  output logic [NCH-1:0]     sclk,
  output logic [NCH-1:0]     tick
);

  localparam logic [DIVBITS-1:0] T_RST  = DIVBITS'(DEFAMT - 1);
  localparam logic [CHW:0]       NCH_LIM = (CHW + 1)'(NCH);

  logic [DIVBITS-1:0] r_q [NCH];
  logic [DIVBITS-1:0] r_t [NCH];
  logic [NCH-1:0]     r_sclk;
  logic [NCH-1:0]     r_tick;
  logic               r_pend;
  logic               r_ready;
  logic [CHW-1:0]     r_pch;
  logic [DIVBITS-1:0] r_pt;

  logic               w_accept;
  logic               w_in_range;
  logic               w_pend_nxt;
  logic [DIVBITS-1:0] w_ld_t;
  logic [NCH-1:0]     w_term;
  logic [NCH-1:0]     w_apply_ch;

  assign w_accept   = ld_valid && r_ready;
  assign w_in_range = ({1'b0, ld_ch} < NCH_LIM);
  // A zero half-period is treated as one, so the stored terminal never underflows.
  assign w_ld_t     = (ld_div == '0) ? '0 : ld_div - DIVBITS'(1);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_term     = '0;
    w_apply_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      w_term[i]     = (r_q[i] == r_t[i]);
      w_apply_ch[i] = r_pend && (r_pch == CHW'(i)) && (sync || !en[i] || w_term[i]);
    end
    w_pend_nxt = r_pend;
    if (|w_apply_ch)              w_pend_nxt = 1'b0;
    if (w_accept && w_in_range)   w_pend_nxt = 1'b1;
  end

  // NOTE: non-blocking assignments for all state, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend  <= 1'b0;
      r_ready <= 1'b0;
      r_pch   <= '0;
      r_pt    <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_ready <= !w_pend_nxt;
      if (w_accept && w_in_range) begin
        r_pch <= ld_ch;
        r_pt  <= w_ld_t;
      end
    end
  end

  // NOTE: the per-channel arrays are ordinary flops, not RAM, so they are reset too.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_q[i] <= '0;
        r_t[i] <= T_RST;
      end
      r_sclk <= '0;
      r_tick <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        // The new terminal lands on the old terminal edge, so no half-period is cut short.
        if (w_apply_ch[i]) r_t[i] <= r_pt;
        if (sync) begin
          r_q[i]    <= '0;
          r_sclk[i] <= 1'b0;
          r_tick[i] <= 1'b0;
        end else if (en[i]) begin
          if (w_term[i]) begin
            r_q[i]    <= '0;
            r_tick[i] <= 1'b1;
            r_sclk[i] <= mode[i] ? 1'b0 : ~r_sclk[i];
          end else begin
            r_q[i]    <= r_q[i] + DIVBITS'(1);
            r_tick[i] <= 1'b0;
            if (mode[i]) r_sclk[i] <= 1'b0;
          end
        end else begin
          r_tick[i] <= 1'b0;
          if (mode[i]) r_sclk[i] <= 1'b0;
        end
      end
    end
  end

  assign sclk     = r_sclk;
  assign tick     = r_tick;
  assign ld_ready = r_ready;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi with a 5-cycle reset half-period on 4 channels.
module tb_clkdiv_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  en = 4'hF;
  logic [3:0]  mode = 4'h0;
  logic        sync = 1'b0;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_ch = 3'd0;
  logic [25:0] ld_div = 26'd0;
  logic        ld_ready;
  logic [3:0]  sclk;
  logic [3:0]  tick;

  int n_checks = 0;
  int n_errors = 0;

  clkdiv_multi #(
    .NCH(4), .DIVBITS(26), .CLKFREQ(100_000_000), .DEFFREQ(2), .DEFAMT(5), .CHW(3)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sync(sync),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_ch(ld_ch), .ld_div(ld_div),
    .sclk(sclk), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; sync = 1'b0; ld_valid = 1'b0; en = 4'hF; mode = 4'h0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] e_t, e_s;
    do_reset();
    reset = 1'b0;
    step();
    if (sclk !== 4'h0) begin n_errors++; $display("FAIL rst_sclk got %b want 0000", sclk); end
    n_checks++;
    if (tick !== 4'h0) begin n_errors++; $display("FAIL rst_tick got %b want 0000", tick); end
    n_checks++;
    if (ld_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready got %b want 0", ld_ready); end
    n_checks++;
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      e_t = (k % 5 == 0) ? 4'hF : 4'h0;
      e_s = ((k / 5) % 2 == 1) ? 4'hF : 4'h0;
      if (tick !== e_t) begin n_errors++; $display("FAIL run_tick k=%0d got %b want %b", k, tick, e_t); end
      n_checks++;
      if (sclk !== e_s) begin n_errors++; $display("FAIL run_sclk k=%0d got %b want %b", k, sclk, e_s); end
      n_checks++;
      if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL run_ready k=%0d got %b want 1", k, ld_ready); end
      n_checks++;
    end
  endtask

  // Continues from test_reset: channel 2 sits at q=1 of t=4 after edge 16.
  task automatic test_load();
    logic [3:0] e_t, e_s;
    logic       e_r;
    ld_valid = 1'b1; ld_ch = 3'd2; ld_div = 26'd3;
    for (int k = 17; k <= 30; k++) begin
      step();
      ld_valid = 1'b0;
      e_t = (k % 5 == 0) ? 4'hF : 4'h0;
      e_s = ((k / 5) % 2 == 1) ? 4'hF : 4'h0;
      if (k >= 20) begin
        e_t[2] = ((k - 20) % 3 == 0) ? 1'b1 : 1'b0;
        e_s[2] = (((k - 20) / 3) % 2 == 1) ? 1'b1 : 1'b0;
      end
      e_r = (k >= 20);
      if (tick !== e_t) begin n_errors++; $display("FAIL load_tick k=%0d got %b want %b", k, tick, e_t); end
      n_checks++;
      if (sclk !== e_s) begin n_errors++; $display("FAIL load_sclk k=%0d got %b want %b", k, sclk, e_s); end
      n_checks++;
      if (ld_ready !== e_r) begin n_errors++; $display("FAIL load_ready k=%0d got %b want %b", k, ld_ready, e_r); end
      n_checks++;
    end
  endtask

  task automatic test_clamp();
    logic e_s;
    do_reset();
    step();
    ld_valid = 1'b1; ld_ch = 3'd1; ld_div = 26'd0;
    step();
    ld_valid = 1'b0;
    if (ld_ready !== 1'b0) begin n_errors++; $display("FAIL clamp_ready_lo got %b want 0", ld_ready); end
    n_checks++;
    repeat (3) step();
    if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL clamp_ready_hi got %b want 1", ld_ready); end
    n_checks++;
    if (sclk[1] !== 1'b1) begin n_errors++; $display("FAIL clamp_sclk5 got %b want 1", sclk[1]); end
    n_checks++;
    for (int k = 6; k <= 12; k++) begin
      step();
      e_s = ((k - 5) % 2 == 0) ? 1'b1 : 1'b0;
      if (tick[1] !== 1'b1) begin n_errors++; $display("FAIL clamp_tick k=%0d got %b want 1", k, tick[1]); end
      n_checks++;
      if (sclk[1] !== e_s) begin n_errors++; $display("FAIL clamp_sclk k=%0d got %b want %b", k, sclk[1], e_s); end
      n_checks++;
      if (tick[0] !== (k == 10)) begin n_errors++; $display("FAIL clamp_ch0 k=%0d got %b want %b", k, tick[0], (k == 10)); end
      n_checks++;
    end
  endtask

  task automatic test_mode();
    do_reset();
    mode = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (sclk[1] !== 1'b0) begin n_errors++; $display("FAIL mode_sclk k=%0d got %b want 0", k, sclk[1]); end
      n_checks++;
      if (tick[1] !== (k % 5 == 0)) begin n_errors++; $display("FAIL mode_tick k=%0d got %b want %b", k, tick[1], (k % 5 == 0)); end
      n_checks++;
    end
    mode = 4'b0000;
    repeat (2) step();
    if (sclk[1] !== 1'b0) begin n_errors++; $display("FAIL mode_back12 got %b want 0", sclk[1]); end
    n_checks++;
    repeat (3) step();
    if (sclk[1] !== 1'b1) begin n_errors++; $display("FAIL mode_back15 got %b want 1", sclk[1]); end
    n_checks++;
  endtask

  task automatic test_enable();
    do_reset();
    repeat (2) step();
    en = 4'b0111;
    for (int k = 3; k <= 9; k++) begin
      step();
      if (tick[3] !== 1'b0 || sclk[3] !== 1'b0) begin
        n_errors++; $display("FAIL en_hold k=%0d got tick=%b sclk=%b want 0 0", k, tick[3], sclk[3]);
      end
      n_checks++;
      if (k == 5) begin
        if (tick !== 4'b0111) begin n_errors++; $display("FAIL en_others got %b want 0111", tick); end
        n_checks++;
      end
    end
    en = 4'hF;
    for (int k = 10; k <= 12; k++) begin
      step();
      if (tick[3] !== (k == 12)) begin n_errors++; $display("FAIL en_resume k=%0d got %b want %b", k, tick[3], (k == 12)); end
      n_checks++;
    end
    if (sclk[3] !== 1'b1) begin n_errors++; $display("FAIL en_sclk12 got %b want 1", sclk[3]); end
    n_checks++;
  endtask

  // Continues from test_enable: channel 3 lags the others by two cycles.
  task automatic test_sync();
    logic [3:0] e_t, e_s;
    step();
    if (sclk !== 4'b1000) begin n_errors++; $display("FAIL sync_desync got %b want 1000", sclk); end
    n_checks++;
    sync = 1'b1;
    step();
    sync = 1'b0;
    if (sclk !== 4'h0 || tick !== 4'h0) begin
      n_errors++; $display("FAIL sync_clear got sclk=%b tick=%b want 0000 0000", sclk, tick);
    end
    n_checks++;
    for (int j = 1; j <= 10; j++) begin
      step();
      e_t = (j % 5 == 0) ? 4'hF : 4'h0;
      e_s = ((j / 5) % 2 == 1) ? 4'hF : 4'h0;
      if (tick !== e_t) begin n_errors++; $display("FAIL sync_tick j=%0d got %b want %b", j, tick, e_t); end
      n_checks++;
      if (sclk !== e_s) begin n_errors++; $display("FAIL sync_sclk j=%0d got %b want %b", j, sclk, e_s); end
      n_checks++;
    end
  endtask

  task automatic test_pending_misc();
    do_reset();
    step();
    if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL pend_ready1 got %b want 1", ld_ready); end
    n_checks++;
    en = 4'b1110;
    ld_valid = 1'b1; ld_ch = 3'd0; ld_div = 26'd2;
    step();
    ld_valid = 1'b0;
    if (ld_ready !== 1'b0) begin n_errors++; $display("FAIL pend_ready2 got %b want 0", ld_ready); end
    n_checks++;
    step();
    if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL pend_dis_apply got %b want 1", ld_ready); end
    n_checks++;
    en = 4'hF;
    step();
    if (tick[0] !== 1'b1 || sclk[0] !== 1'b1) begin
      n_errors++; $display("FAIL pend_newt got tick=%b sclk=%b want 1 1", tick[0], sclk[0]);
    end
    n_checks++;
    ld_valid = 1'b1; ld_ch = 3'd5; ld_div = 26'd9;
    step();
    ld_valid = 1'b0;
    if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL oor_ready got %b want 1", ld_ready); end
    n_checks++;
    if (tick !== 4'b1110) begin n_errors++; $display("FAIL oor_tick got %b want 1110", tick); end
    n_checks++;
    step();
    if (tick !== 4'b0001 || sclk[0] !== 1'b0) begin
      n_errors++; $display("FAIL pend_period2 got tick=%b sclk0=%b want 0001 0", tick, sclk[0]);
    end
    n_checks++;
    ld_valid = 1'b1; ld_ch = 3'd1; ld_div = 26'd2;
    step();
    ld_valid = 1'b0;
    if (ld_ready !== 1'b0) begin n_errors++; $display("FAIL rstpend_ready got %b want 0", ld_ready); end
    n_checks++;
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    if (sclk !== 4'h0 || ld_ready !== 1'b0) begin
      n_errors++; $display("FAIL rstpend_clear got sclk=%b ready=%b want 0000 0", sclk, ld_ready);
    end
    n_checks++;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (tick !== ((k == 5) ? 4'hF : 4'h0)) begin
        n_errors++; $display("FAIL rstpend_tick k=%0d got %b want %b", k, tick, (k == 5) ? 4'hF : 4'h0);
      end
      n_checks++;
      if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL rstpend_ready k=%0d got %b want 1", k, ld_ready); end
      n_checks++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_clamp();
    test_mode();
    test_enable();
    test_sync();
    test_pending_misc();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
